mcu_spi: RTL and testbench

SPI target that terminates the serial link from the IO MCU and converts it into the parallel byte stream used by the on-chip MCU targets (system control, OSD, HID and SD card). Each SPI transaction carries a target byte and then a command/payload stream. The block delivers each payload byte to the selected target as a one-cycle strobe with a start flag. It shifts the addressed target's reply byte back to the MCU on MISO. It sits directly upstream of the HID block and feeds that block's strobe, start and data inputs.

---
 rtl/mcu_spi_pkg.sv | 24 ++
 rtl/mcu_spi_sync_edge.sv | 26 ++
 rtl/mcu_spi.sv | 175 +++++++++++++++++
 tb/tb_mcu_spi.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_spi_pkg.sv
// Shared constants and types for the IO-MCU SPI target.
// Target IDs select which on-chip MCU target sees the payload.
package mcu_spi_pkg;

  localparam logic [7:0] TGT_SYS  = 8'd0;
  localparam logic [7:0] TGT_OSD  = 8'd1;
  localparam logic [7:0] TGT_HID  = 8'd2;
  localparam logic [7:0] TGT_SDC  = 8'd3;
  localparam logic [7:0] TGT_NONE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    TARGET,
    CMD,
    DATA
  } state_t;

  function automatic logic tgt_valid(
    input logic [7:0] t
  );
    return t[7:2] == 6'd0;
  endfunction

endpackage

// File: rtl/mcu_spi_sync_edge.sv
// N-stage synchronizer for an asynchronous SPI pin with
// rise/fall detection on the synchronized level.
module spi_sync_edge #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [N-1:0] sync;
  logic         q_d;

  // Free-running, so a reset never manufactures a fake edge.
  always_ff @(posedge clk) begin
    sync <= {sync[N-2:0], din};
    q_d  <= sync[N-1];
  end

  assign q    = sync[N-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/mcu_spi.sv
// SPI mode-0 target: target byte, then command/payload bytes
// strobed to the selected MCU target, reply shifted on MISO.
module mcu_spi
  import mcu_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] data_in,
  output logic       data_in_start,
  output logic       sys_strobe,
  output logic       osd_strobe,
  output logic       hid_strobe,
  output logic       sdc_strobe,
  input  logic [7:0] sys_data_out,
  input  logic [7:0] osd_data_out,
  input  logic [7:0] hid_data_out,
  input  logic [7:0] sdc_data_out
);

  logic sck_unused;
  logic sck_rise;
  logic sck_fall;
  logic ss_q;
  logic ss_rise_unused;
  logic ss_fall;

  spi_sync_edge #(.N(SYNC_STAGES)) u_sck (
    .clk  (clk),
    .din  (spi_sck),
    .q    (sck_unused),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.N(SYNC_STAGES)) u_ss (
    .clk  (clk),
    .din  (spi_ss_n),
    .q    (ss_q),
    .rise (ss_rise_unused),
    .fall (ss_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_q;

  always_ff @(posedge clk) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end

  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  state_t     state;
  state_t     state_n;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_next;
  logic [7:0] target;
  logic [7:0] tx_shift;
  logic [7:0] tx_next;
  logic [7:0] reply_sel;
  logic [3:0] strobe_q;
  logic [3:0] strobe_n;
  logic       active;
  logic       rise_v;
  logic       fall_v;
  logic       byte_done;
  logic       load_pl;
  logic       start_n;

  // A high ss_n overrides any SCK edge seen in the same cycle.
  assign active    = ~ss_q;
  assign rise_v    = sck_rise & active & (state != IDLE);
  assign fall_v    = sck_fall & active & (state != IDLE);
  assign rx_next   = {rx_shift, mosi_q};
  assign byte_done = rise_v & (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (!active) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (ss_fall)   state_n = TARGET;
        TARGET:  if (byte_done) state_n = CMD;
        CMD:     if (byte_done) state_n = DATA;
        DATA:    state_n = DATA;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    reply_sel = 8'h00;
    case (target)
      TGT_SYS: reply_sel = sys_data_out;
      TGT_OSD: reply_sel = osd_data_out;
      TGT_HID: reply_sel = hid_data_out;
      TGT_SDC: reply_sel = sdc_data_out;
      default: reply_sel = 8'h00;
    endcase
  end

  always_comb begin
    strobe_n = 4'b0000;
    load_pl  = 1'b0;
    start_n  = 1'b0;
    tx_next  = tx_shift;
    if ((state == CMD || state == DATA) && byte_done &&
        tgt_valid(target)) begin
      load_pl  = 1'b1;
      start_n  = (state == CMD);
      strobe_n = 4'b0001 << target[1:0];
    end
    // Reply loads on the 8th fall; the CMD byte still returns zero.
    if (!active) begin
      tx_next = 8'h00;
    end else if (fall_v) begin
      if (bit_cnt == 3'd0) begin
        tx_next = (state == DATA) ? reply_sel : 8'h00;
      end else begin
        tx_next = {tx_shift[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt       <= 3'd0;
      rx_shift      <= 7'd0;
      target        <= TGT_NONE;
      tx_shift      <= 8'h00;
      strobe_q      <= 4'b0000;
      data_in       <= 8'h00;
      data_in_start <= 1'b0;
    end else begin
      strobe_q <= strobe_n;
      tx_shift <= tx_next;
      if (!active) begin
        bit_cnt <= 3'd0;
        target  <= TGT_NONE;
      end else if (rise_v) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_next[6:0];
        if (byte_done && state == TARGET) begin
          target <= rx_next;
        end
      end
      if (load_pl) begin
        data_in       <= rx_next;
        data_in_start <= start_n;
      end
    end
  end

  assign spi_miso   = tx_shift[7];
  assign sys_strobe = strobe_q[0];
  assign osd_strobe = strobe_q[1];
  assign hid_strobe = strobe_q[2];
  assign sdc_strobe = strobe_q[3];

endmodule

// File: tb/tb_mcu_spi.sv
// Scoreboard bench for mcu_spi: SPI master driver, strobe
// monitor, MISO monitor and a transaction-level reply model.
module tb_mcu_spi;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int         tgt;
    logic [7:0] data;
    logic       start;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] data_in;
  logic       data_in_start;
  logic       sys_s, osd_s, hid_s, sdc_s;
  logic [7:0] reply [4];

  int vecs = 0;
  int errs = 0;

  exp_t       sq[$];
  logic [7:0] mq[$];
  logic [7:0] plan[$];

  mcu_spi #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .spi_sck       (sck),
    .spi_ss_n      (ss_n),
    .spi_mosi      (mosi),
    .spi_miso      (miso),
    .data_in       (data_in),
    .data_in_start (data_in_start),
    .sys_strobe    (sys_s),
    .osd_strobe    (osd_s),
    .hid_strobe    (hid_s),
    .sdc_strobe    (sdc_s),
    .sys_data_out  (reply[0]),
    .osd_data_out  (reply[1]),
    .hid_data_out  (reply[2]),
    .sdc_data_out  (reply[3])
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Strobe monitor: pops the scoreboard on every strobe.
  logic [3:0] s_vec;
  exp_t       e;

  always @(negedge clk) begin
    if (!reset) begin
      s_vec = {sdc_s, hid_s, osd_s, sys_s};
      if (s_vec != 4'b0000) begin
        check("strobe_onehot", $countones(s_vec), 1);
        check("strobe_expected", sq.size() > 0, 1);
        if (sq.size() > 0) begin
          e = sq.pop_front();
          check("strobe_target", s_vec, 4'b0001 << e.tgt);
          check("data_in", data_in, e.data);
          check("data_in_start", data_in_start, e.start);
        end
      end
    end
  end

  // Target responder: adopts the next planned reply after a strobe.
  always @(negedge clk) begin
    if (!reset && plan.size() > 0) begin
      if (sys_s) reply[0] = plan.pop_front();
      else if (osd_s) reply[1] = plan.pop_front();
      else if (hid_s) reply[2] = plan.pop_front();
      else if (sdc_s) reply[3] = plan.pop_front();
    end
  end

  // MISO monitor: assembles whole bytes as the master samples them.
  int         mbits = 0;
  logic [7:0] mbyte = 8'h00;

  always @(posedge sck or posedge ss_n or posedge reset) begin
    if (ss_n || reset) begin
      mbits = 0;
    end else begin
      mbyte = {mbyte[6:0], miso};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        check("miso_expected", mq.size() > 0, 1);
        if (mq.size() > 0) check("miso_byte", mbyte, mq.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // SCK = clk/8, mode 0, MSB first.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic txn(input bq_t b, input int gap);
    int         tgt;
    bit         ok;
    logic [7:0] m;
    int         pi;
    tgt = int'(b[0]);
    ok  = tgt < 4;
    m   = ok ? reply[tgt] : 8'h00;
    pi  = 0;
    mq.push_back(8'h00);
    for (int i = 1; i < b.size(); i++) begin
      mq.push_back((i == 1 || !ok) ? 8'h00 : m);
      if (ok) begin
        sq.push_back('{tgt: tgt, data: b[i], start: (i == 1)});
        if (pi < plan.size()) begin
          m = plan[pi];
          pi++;
        end
      end
    end
    ss_n = 1'b0;
    tick(4);
    foreach (b[i]) send_bits(b[i], 8);
    tick(4);
    ss_n = 1'b1;
    tick(gap);
    check("strobes_drained", sq.size(), 0);
    check("miso_drained", mq.size(), 0);
    plan.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", miso, 0);
    check("rst_data_in", data_in, 0);
    check("rst_start", data_in_start, 0);
    check("rst_strobes", {sdc_s, hid_s, osd_s, sys_s}, 0);
  endtask

  bq_t q;

  initial begin
    foreach (reply[i]) reply[i] = 8'h00;
    tick(5);
    reset = 1'b0;
    tick(2);
    check_reset_outputs();

    q = '{8'h02, 8'h01, 8'h85};
    txn(q, 8);

    reply[0] = 8'h5C;
    plan = '{8'h5C, 8'h42};
    q = '{8'h00, 8'h00, 8'hAA, 8'hAA};
    txn(q, 8);

    // Abort partway through the command byte.
    ss_n = 1'b0;
    tick(4);
    mq.push_back(8'h00);
    send_bits(8'h02, 8);
    send_bits(8'hFF, 5);
    tick(4);
    ss_n = 1'b1;
    tick(8);
    check("abort_no_strobe", sq.size(), 0);
    q = '{8'h02, 8'h03};
    txn(q, 8);

    foreach (reply[i]) reply[i] = 8'hA5;
    q = '{8'h07, 8'h11, 8'h22};
    txn(q, 8);

    // Reset mid command byte, then a byte while ss_n never rose.
    ss_n = 1'b0;
    tick(4);
    mq.push_back(8'h00);
    send_bits(8'h03, 8);
    send_bits(8'h04, 4);
    reset = 1'b1;
    tick(2);
    check_reset_outputs();
    reset = 1'b0;
    tick(2);
    mq.push_back(8'h00);
    send_bits(8'h55, 8);
    tick(4);
    ss_n = 1'b1;
    tick(8);
    check("post_reset_no_strobe", sq.size(), 0);
    q = '{8'h03, 8'h04};
    txn(q, 8);

    q = '{8'h01, 8'h10};
    txn(q, 4);
    q = '{8'h02, 8'h20};
    txn(q, 8);

    for (int t = 0; t < 24; t++) begin
      int tg;
      int n;
      tg = $urandom_range(0, 5);
      if (tg == 5) tg = $urandom_range(4, 255);
      n = $urandom_range(1, 4);
      q = '{};
      q.push_back(8'(tg));
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      foreach (reply[i]) reply[i] = 8'($urandom);
      for (int k = 0; k < $urandom_range(0, n); k++)
        plan.push_back(8'($urandom));
      txn(q, $urandom_range(4, 12));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
